// File: rtl/ib_ram_pkg.sv
// Shared definitions for the IB-RAM write path: loader state encoding,
// bank-interleave address formats and width helpers.
package ib_ram_pkg;

  typedef enum logic [1:0] {
    IB_LD_IDLE,
    IB_LD_PACK,
    IB_LD_WRITE,
    IB_LD_DONE
  } ib_ld_state_t;

  localparam int IB_BANK_ILV_BANK_PAGE = 0;
  localparam int IB_BANK_ILV_PAGE_BANK = 1;

  function automatic int ib_bank_addr_width(input int bank_num);
    return $clog2(bank_num);
  endfunction

  // Slot counter never collapses to zero bits, even for a single-word page.
  function automatic int ib_slot_cnt_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/ib_ram_word_packer.sv
// Collects WORDS consecutive words into one page vector, slot 0 in the low bits.
// packed_o already includes the word being strobed this cycle.
module ib_ram_word_packer
  import ib_ram_pkg::*;
#(
  parameter int WORDS  = 2,
  parameter int WORD_W = 4
) (
  input  logic                      sys_clk,
  input  logic                      rst,
  input  logic                      clr_i,
  input  logic                      strobe_i,
  input  logic [WORD_W-1:0]         data_i,
  output logic                      full_o,
  output logic [WORDS*WORD_W-1:0]   packed_o
);

  localparam int CNT_W = ib_slot_cnt_width(WORDS);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(WORDS - 1);

  logic [CNT_W-1:0]        slot_q, slot_d;
  logic [WORDS*WORD_W-1:0] packed_q, packed_d;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    slot_d   = slot_q;
    packed_d = packed_q;
    if (clr_i) begin
      slot_d = '0;
    end else if (strobe_i) begin
      packed_d[int'(slot_q)*WORD_W +: WORD_W] = data_i;
      slot_d = (slot_q == LAST_SLOT) ? '0 : slot_q + 1'b1;
    end
  end

  assign full_o   = strobe_i && !clr_i && (slot_q == LAST_SLOT);
  assign packed_o = packed_d;

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sys_clk) begin
    if (rst) slot_q <= '0;
    else     slot_q <= slot_d;
  end

  // NOTE: slot storage is left unreset; it is only consumed after every slot of the page has been rewritten.
  always_ff @(posedge sys_clk) begin
    packed_q <= packed_d;
  end

endmodule

// File: rtl/ib_ram_page_loader.sv
// Streams PAGE_SIZE-bit words into BANK_INTERLEAVE_NUM-word pages and writes
// each page to the interleaved IB-RAM at consecutive page addresses.
module ib_ram_page_loader
  import ib_ram_pkg::*;
#(
  parameter int BANK_INTERLEAVE_TYPE = IB_BANK_ILV_BANK_PAGE,
  parameter int BANK_INTERLEAVE_NUM  = 2,
  parameter int ADDR_WIDTH           = 6,
  parameter int BANK_ADDR_WIDTH      = ib_bank_addr_width(BANK_INTERLEAVE_NUM),
  parameter int PAGE_ADDR_WIDTH      = ADDR_WIDTH - BANK_ADDR_WIDTH,
  parameter int PAGE_SIZE            = 4,
  parameter int WDATA_SIZE           = PAGE_SIZE * BANK_INTERLEAVE_NUM,
  parameter int PAGE_NUM             = 32
) (
  input  logic                       sys_clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic [PAGE_ADDR_WIDTH-1:0] base_page_i,
  input  logic [PAGE_ADDR_WIDTH:0]   page_cnt_i,
  input  logic                       abort_i,
  input  logic [PAGE_SIZE-1:0]       in_data_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  output logic [WDATA_SIZE-1:0]      wdata_o,
  output logic [ADDR_WIDTH-1:0]      access_addr_o,
  output logic                       wen_n_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o
);

  localparam int CHK_W = PAGE_ADDR_WIDTH + 2;
  localparam logic [PAGE_ADDR_WIDTH:0] REMAIN_ONE = (PAGE_ADDR_WIDTH+1)'(1);

  ib_ld_state_t               state_q, state_d;
  logic [PAGE_ADDR_WIDTH-1:0] cur_page_q, cur_page_d;
  logic [PAGE_ADDR_WIDTH:0]   remain_q, remain_d;
  logic [WDATA_SIZE-1:0]      wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic                       wen_n_q, wen_n_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       err_q, err_d;

  logic [ADDR_WIDTH-1:0]      page_addr;
  logic [CHK_W-1:0]           range_end;
  logic                       start_bad;
  logic                       pk_clr, pk_strobe, pk_full;
  logic [WDATA_SIZE-1:0]      pk_packed;

  assign in_ready_o = (state_q == IB_LD_PACK);
  assign pk_strobe  = in_valid_i && in_ready_o;

  ib_ram_word_packer #(
    .WORDS  (BANK_INTERLEAVE_NUM),
    .WORD_W (PAGE_SIZE)
  ) u_packer (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .clr_i    (pk_clr),
    .strobe_i (pk_strobe),
    .data_i   (in_data_i),
    .full_o   (pk_full),
    .packed_o (pk_packed)
  );

  // A page write hits every bank at once, so the bank field is always zero.
  always_comb begin
    if (BANK_INTERLEAVE_TYPE == IB_BANK_ILV_PAGE_BANK)
      page_addr = ADDR_WIDTH'(cur_page_q) << BANK_ADDR_WIDTH;
    else
      page_addr = ADDR_WIDTH'(cur_page_q);
  end

  assign range_end = CHK_W'(base_page_i) + CHK_W'(page_cnt_i);
  assign start_bad = (page_cnt_i == '0) || (range_end > CHK_W'(PAGE_NUM));

  always_comb begin
    state_d    = state_q;
    cur_page_d = cur_page_q;
    remain_d   = remain_q;
    wdata_d    = wdata_q;
    addr_d     = addr_q;
    wen_n_d    = 1'b1;
    done_d     = 1'b0;
    err_d      = 1'b0;
    pk_clr     = 1'b0;
    case (state_q)
      IB_LD_IDLE: begin
        if (start_i) begin
          if (start_bad) begin
            err_d = 1'b1;
          end else begin
            cur_page_d = base_page_i;
            remain_d   = page_cnt_i;
            pk_clr     = 1'b1;
            state_d    = IB_LD_PACK;
          end
        end
      end
      IB_LD_PACK: begin
        // Abort wins over a completing page: the partial page is dropped.
        if (abort_i) begin
          state_d = IB_LD_IDLE;
        end else if (pk_full) begin
          wdata_d = pk_packed;
          addr_d  = page_addr;
          wen_n_d = 1'b0;
          state_d = IB_LD_WRITE;
        end
      end
      IB_LD_WRITE: begin
        cur_page_d = cur_page_q + 1'b1;
        remain_d   = remain_q - 1'b1;
        pk_clr     = 1'b1;
        if (abort_i)                 state_d = IB_LD_IDLE;
        else if (remain_q == REMAIN_ONE) state_d = IB_LD_DONE;
        else                         state_d = IB_LD_PACK;
      end
      IB_LD_DONE: begin
        done_d  = !abort_i;
        state_d = IB_LD_IDLE;
      end
      default: state_d = IB_LD_IDLE;
    endcase
    busy_d = (state_d != IB_LD_IDLE);
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q    <= IB_LD_IDLE;
      cur_page_q <= '0;
      remain_q   <= '0;
      wdata_q    <= '0;
      addr_q     <= '0;
      wen_n_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_page_q <= cur_page_d;
      remain_q   <= remain_d;
      wdata_q    <= wdata_d;
      addr_q     <= addr_d;
      wen_n_q    <= wen_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign wdata_o       = wdata_q;
  assign access_addr_o = addr_q;
  assign wen_n_o       = wen_n_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_ib_ram_page_loader.sv
// Bench for ib_ram_page_loader: a vector table of loads plus hand sequences,
// with a write scoreboard shared by a type-0 and a type-1 instance.
module tb_ib_ram_page_loader;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_i = 1'b0;
  logic [4:0] base_page_i = '0;
  logic [5:0] page_cnt_i = '0;
  logic       abort_i = 1'b0;
  logic [3:0] in_data_i = '0;
  logic       in_valid_i = 1'b0;

  logic       in_ready_o, wen_n_o, busy_o, done_o, err_o;
  logic [7:0] wdata_o;
  logic [5:0] access_addr_o;

  logic       ready1, wen1_n, busy1, done1, err1;
  logic [7:0] wdata1;
  logic [5:0] addr1;

  typedef struct packed {
    logic [4:0] page;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    logic [4:0] base;
    logic [5:0] cnt;
    bit         exp_err;
    bit         gaps;
    logic [3:0] seed;
  } vec_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  cyc = 0;
  int  done_cnt = 0;
  int  start_cyc = 0;
  int  last_wr_cyc = 0;

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  ib_ram_page_loader dut (
    .sys_clk(sys_clk), .rst(rst), .start_i(start_i), .base_page_i(base_page_i),
    .page_cnt_i(page_cnt_i), .abort_i(abort_i), .in_data_i(in_data_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .wdata_o(wdata_o),
    .access_addr_o(access_addr_o), .wen_n_o(wen_n_o), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o)
  );

  ib_ram_page_loader #(.BANK_INTERLEAVE_TYPE(1)) dut_pb (
    .sys_clk(sys_clk), .rst(rst), .start_i(start_i), .base_page_i(base_page_i),
    .page_cnt_i(page_cnt_i), .abort_i(abort_i), .in_data_i(in_data_i),
    .in_valid_i(in_valid_i), .in_ready_o(ready1), .wdata_o(wdata1),
    .access_addr_o(addr1), .wen_n_o(wen1_n), .busy_o(busy1),
    .done_o(done1), .err_o(err1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every active-low write is popped against the scoreboard.
  always @(negedge sys_clk) begin
    wr_t e;
    if (wen_n_o == 1'b0) begin
      last_wr_cyc = cyc;
      check("in_ready_low_in_write", 32'(in_ready_o), 32'(0));
      check("type1_wen", 32'(wen1_n), 32'(0));
      check("write_expected", 32'(exp_q.size() > 0), 32'(1));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wdata", 32'(wdata_o), 32'(e.data));
        check("addr_type0", 32'(access_addr_o), 32'({1'b0, e.page}));
        check("addr_type1", 32'(addr1), 32'({e.page, 1'b0}));
        check("type1_wdata", 32'(wdata1), 32'(e.data));
      end
    end
    if (done_o) done_cnt++;
  end

  task automatic check_reset(input string tag);
    check({tag, "_wen_n"},  32'(wen_n_o),       32'(1));
    check({tag, "_wdata"},  32'(wdata_o),       32'(0));
    check({tag, "_addr"},   32'(access_addr_o), 32'(0));
    check({tag, "_ready"},  32'(in_ready_o),    32'(0));
    check({tag, "_busy"},   32'(busy_o),        32'(0));
    check({tag, "_done"},   32'(done_o),        32'(0));
    check({tag, "_err"},    32'(err_o),         32'(0));
  endtask

  // Called and returns just after a rising edge.
  task automatic do_start(input logic [4:0] base, input logic [5:0] cnt);
    start_i = 1'b1;
    base_page_i = base;
    page_cnt_i = cnt;
    start_cyc = cyc;
    @(posedge sys_clk); #1;
    start_i = 1'b0;
  endtask

  task automatic drive_word(input logic [3:0] d);
    bit took = 1'b0;
    int budget = 0;
    in_valid_i = 1'b1;
    in_data_i = d;
    while (!took && budget < 20) begin
      @(negedge sys_clk);
      took = in_ready_o;
      @(posedge sys_clk); #1;
      budget++;
    end
    check("word_accepted", 32'(took), 32'(1));
  endtask

  task automatic run_load(input logic [4:0] base, input logic [5:0] cnt,
                          input bit exp_err, input bit gaps, input logic [3:0] seed);
    int  d0 = done_cnt;
    int  acc = 0;
    int  budget = 0;
    bit  took;
    logic [4:0] pg;
    logic [7:0] last_data = '0;
    do_start(base, cnt);
    if (exp_err) begin
      @(negedge sys_clk);
      check("err_pulse", 32'(err_o), 32'(1));
      check("busy_on_err", 32'(busy_o), 32'(0));
      @(negedge sys_clk);
      check("err_one_cycle", 32'(err_o), 32'(0));
      check("busy_stays_low", 32'(busy_o), 32'(0));
      check("no_done_on_err", 32'(done_cnt - d0), 32'(0));
      @(posedge sys_clk); #1;
      return;
    end
    for (int p = 0; p < int'(cnt); p++) begin
      pg = base + 5'(p);
      last_data = {4'(seed + 2*p + 1), 4'(seed + 2*p)};
      exp_q.push_back('{page: pg, data: last_data});
    end
    while (acc < 2*int'(cnt) && budget < 600) begin
      in_data_i  = 4'(seed + acc);
      in_valid_i = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge sys_clk);
      if (budget == 0) check("busy_during_load", 32'(busy_o), 32'(1));
      took = in_valid_i && in_ready_o;
      @(posedge sys_clk); #1;
      if (took) acc++;
      budget++;
    end
    in_valid_i = 1'b0;
    check("all_words_taken", 32'(acc), 32'(2*int'(cnt)));
    budget = 0;
    do begin
      @(negedge sys_clk);
      budget++;
    end while (!done_o && budget < 10);
    check("done_pulse", 32'(done_o), 32'(1));
    if (!gaps) check("load_cycles", 32'(cyc - start_cyc), 32'(2 + 3*int'(cnt)));
    @(negedge sys_clk);
    check("done_one_cycle", 32'(done_o), 32'(0));
    check("busy_after_done", 32'(busy_o), 32'(0));
    check("done_count", 32'(done_cnt - d0), 32'(1));
    check("sb_drained", 32'(exp_q.size()), 32'(0));
    check("wdata_hold", 32'(wdata_o), 32'(last_data));
    check("addr_hold", 32'(access_addr_o), 32'({1'b0, 5'(base + 5'(cnt) - 5'd1)}));
    @(posedge sys_clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs[8];
    int   d0;

    vecs[0] = '{5'd0,  6'd32, 1'b0, 1'b0, 4'h0};
    vecs[1] = '{5'd30, 6'd3,  1'b1, 1'b0, 4'h0};
    vecs[2] = '{5'd4,  6'd0,  1'b1, 1'b0, 4'h0};
    vecs[3] = '{5'd7,  6'd2,  1'b0, 1'b1, 4'h5};
    vecs[4] = '{5'd31, 6'd1,  1'b0, 1'b0, 4'h9};
    vecs[5] = '{5'd1,  6'd32, 1'b1, 1'b0, 4'h0};
    vecs[6] = '{5'd30, 6'd2,  1'b0, 1'b0, 4'h3};
    vecs[7] = '{5'd31, 6'd63, 1'b1, 1'b0, 4'h0};

    repeat (2) begin
      @(negedge sys_clk);
      check_reset("init");
    end
    @(posedge sys_clk); #1;
    rst = 1'b0;

    // Single page, valid held across both words.
    d0 = done_cnt;
    exp_q.push_back('{page: 5'd5, data: 8'h3A});
    do_start(5'd5, 6'd1);
    drive_word(4'hA);
    drive_word(4'h3);
    in_valid_i = 1'b0;
    @(negedge sys_clk);
    check("wen_low_after_last_word", 32'(wen_n_o), 32'(0));
    repeat (2) @(negedge sys_clk);
    check("single_done", 32'(done_o), 32'(1));
    check("done_after_write", 32'(cyc - last_wr_cyc), 32'(2));
    check("single_cycles", 32'(cyc - start_cyc), 32'(5));
    @(posedge sys_clk); #1;
    check("single_done_count", 32'(done_cnt - d0), 32'(1));

    for (int i = 0; i < 8; i++)
      run_load(vecs[i].base, vecs[i].cnt, vecs[i].exp_err, vecs[i].gaps, vecs[i].seed);

    // Abort after the first word of the third page.
    d0 = done_cnt;
    exp_q.push_back('{page: 5'd0, data: 8'h10});
    exp_q.push_back('{page: 5'd1, data: 8'h32});
    do_start(5'd0, 6'd3);
    for (int w = 0; w < 5; w++) drive_word(4'(w));
    in_valid_i = 1'b0;
    abort_i = 1'b1;
    @(posedge sys_clk); #1;
    abort_i = 1'b0;
    @(negedge sys_clk);
    check("abort_pack_busy", 32'(busy_o), 32'(0));
    check("abort_pack_ready", 32'(in_ready_o), 32'(0));
    repeat (6) @(negedge sys_clk);
    check("abort_pack_no_done", 32'(done_cnt - d0), 32'(0));
    check("abort_pack_sb", 32'(exp_q.size()), 32'(0));
    @(posedge sys_clk); #1;

    // Abort raised during the WRITE cycle: that write still lands.
    d0 = done_cnt;
    exp_q.push_back('{page: 5'd10, data: 8'h76});
    do_start(5'd10, 6'd2);
    drive_word(4'h6);
    drive_word(4'h7);
    in_valid_i = 1'b0;
    abort_i = 1'b1;
    @(negedge sys_clk);
    check("abort_write_wen", 32'(wen_n_o), 32'(0));
    @(posedge sys_clk); #1;
    abort_i = 1'b0;
    @(negedge sys_clk);
    check("abort_write_busy", 32'(busy_o), 32'(0));
    repeat (6) @(negedge sys_clk);
    check("abort_write_no_done", 32'(done_cnt - d0), 32'(0));
    check("abort_write_sb", 32'(exp_q.size()), 32'(0));
    @(posedge sys_clk); #1;

    // Reset in the middle of packing, then a normal load.
    do_start(5'd3, 6'd2);
    drive_word(4'h1);
    in_valid_i = 1'b0;
    rst = 1'b1;
    @(posedge sys_clk); #1;
    rst = 1'b0;
    check_reset("mid_load");
    run_load(5'd3, 6'd2, 1'b0, 1'b0, 4'h8);

    check("final_sb_empty", 32'(exp_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
